// File: rtl/reg_bank_16x16.sv
// reg_bank_16x16: sixteen WIDTH-bit registers plus a FLAG_W-bit status register.
// The bank has one write-back port with a valid/ready handshake.
// A one-entry hold buffer absorbs one write while the datapath is stalled.
// Optional build macro REG_BANK_R0_ZERO_EN: r0 reads as constant zero and has no storage.
module reg_bank_16x16 #(
  parameter int WIDTH  = 16,
  parameter int FLAG_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [3:0]        wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              stall,
  input  logic              flags_we,
  input  logic [FLAG_W-1:0] flags_in,
  output logic [WIDTH-1:0]  r0,
  output logic [WIDTH-1:0]  r1,
  output logic [WIDTH-1:0]  r2,
  output logic [WIDTH-1:0]  r3,
  output logic [WIDTH-1:0]  r4,
  output logic [WIDTH-1:0]  r5,
  output logic [WIDTH-1:0]  r6,
  output logic [WIDTH-1:0]  r7,
  output logic [WIDTH-1:0]  r8,
  output logic [WIDTH-1:0]  r9,
  output logic [WIDTH-1:0]  r10,
  output logic [WIDTH-1:0]  r11,
  output logic [WIDTH-1:0]  r12,
  output logic [WIDTH-1:0]  r13,
  output logic [WIDTH-1:0]  r14,
  output logic [WIDTH-1:0]  r15,
  output logic [FLAG_W-1:0] psr,
  output logic              pend_valid
);

  logic [WIDTH-1:0]  regs [1:15];
  logic [3:0]        pend_addr;
  logic [WIDTH-1:0]  pend_data;

  logic              accept;
  logic              commit_en;
  logic [3:0]        commit_addr;
  logic [WIDTH-1:0]  commit_data;
  logic              pend_load;
  logic              pend_valid_nxt;

  assign wr_ready = !pend_valid || !stall;
  assign accept   = wr_valid && wr_ready;

  // Choose the single register commit for this edge and the hold-buffer update.
  // The buffered write always commits before a newly accepted one, which keeps program order.
  always_comb begin
    commit_en      = 1'b0;
    commit_addr    = wr_addr;
    commit_data    = wr_data;
    pend_load      = 1'b0;
    pend_valid_nxt = pend_valid;
    if (!stall) begin
      if (pend_valid) begin
        commit_en      = 1'b1;
        commit_addr    = pend_addr;
        commit_data    = pend_data;
        pend_load      = accept;
        pend_valid_nxt = accept;
      end else if (accept) begin
        commit_en = 1'b1;
      end
    end else if (!pend_valid && accept) begin
      pend_load      = 1'b1;
      pend_valid_nxt = 1'b1;
    end
  end

  // Hold buffer: capture a write that cannot commit yet.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_valid <= 1'b0;
      pend_addr  <= '0;
      pend_data  <= '0;
    end else begin
      pend_valid <= pend_valid_nxt;
      if (pend_load) begin
        pend_addr <= wr_addr;
        pend_data <= wr_data;
      end
    end
  end

  // Registers r1..r15 take the selected commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 1; i < 16; i++) regs[i] <= '0;
    end else begin
      for (int i = 1; i < 16; i++)
        if (commit_en && commit_addr == 4'(i)) regs[i] <= commit_data;
    end
  end

`ifdef REG_BANK_R0_ZERO_EN
  assign r0 = '0;
`else
  logic [WIDTH-1:0] reg0;

  // r0 behaves like any other register in this build.
  always_ff @(posedge clk) begin
    if (reset)                                reg0 <= '0;
    else if (commit_en && commit_addr == 4'd0) reg0 <= commit_data;
  end

  assign r0 = reg0;
`endif

  // Status register loads whenever requested, regardless of stall or the write port.
  always_ff @(posedge clk) begin
    if (reset)         psr <= '0;
    else if (flags_we) psr <= flags_in;
  end

  assign r1  = regs[1];
  assign r2  = regs[2];
  assign r3  = regs[3];
  assign r4  = regs[4];
  assign r5  = regs[5];
  assign r6  = regs[6];
  assign r7  = regs[7];
  assign r8  = regs[8];
  assign r9  = regs[9];
  assign r10 = regs[10];
  assign r11 = regs[11];
  assign r12 = regs[12];
  assign r13 = regs[13];
  assign r14 = regs[14];
  assign r15 = regs[15];

endmodule

// File: tb/tb_reg_bank_16x16.sv
// Bench for reg_bank_16x16.
// The reference model keeps accepted writes in an in-order queue.
// Each unstalled edge retires one queued write.
module tb_reg_bank_16x16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [3:0]  wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic        stall = 1'b0;
  logic        flags_we = 1'b0;
  logic [4:0]  flags_in = '0;
  logic [15:0] r_out [16];
  logic [4:0]  psr;
  logic        pend_valid;

  reg_bank_16x16 dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .stall(stall),
    .flags_we(flags_we), .flags_in(flags_in),
    .r0(r_out[0]),   .r1(r_out[1]),   .r2(r_out[2]),   .r3(r_out[3]),
    .r4(r_out[4]),   .r5(r_out[5]),   .r6(r_out[6]),   .r7(r_out[7]),
    .r8(r_out[8]),   .r9(r_out[9]),   .r10(r_out[10]), .r11(r_out[11]),
    .r12(r_out[12]), .r13(r_out[13]), .r14(r_out[14]), .r15(r_out[15]),
    .psr(psr), .pend_valid(pend_valid)
  );

  always #5 clk = ~clk;

`ifdef REG_BANK_R0_ZERO_EN
  localparam bit R0_ZERO = 1'b1;
`else
  localparam bit R0_ZERO = 1'b0;
`endif

  typedef struct {
    logic [3:0]  a;
    logic [15:0] d;
  } wr_t;

  logic [15:0] m_reg [16];
  logic [4:0]  m_psr;
  wr_t         m_q [$];
  bit          m_known = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // One clock cycle.
  // Drive the inputs, check wr_ready before the edge, advance the model at the edge,
  // then check all outputs just after the edge.
  task automatic cycle(input bit rst, input bit wv, input logic [3:0] wa,
                       input logic [15:0] wd, input bit st, input bit fwe,
                       input logic [4:0] fin);
    bit  ready;
    wr_t w;
    reset = rst; wr_valid = wv; wr_addr = wa; wr_data = wd;
    stall = st; flags_we = fwe; flags_in = fin;
    #1;
    ready = (m_q.size() == 0) || !st;
    if (m_known) check("wr_ready", {31'b0, wr_ready}, {31'b0, ready});
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 16; i++) m_reg[i] = '0;
      m_q.delete();
      m_psr   = '0;
      m_known = 1'b1;
    end else begin
      if (wv && ready) m_q.push_back('{a: wa, d: wd});
      if (!st && m_q.size() > 0) begin
        w = m_q.pop_front();
        if (!(R0_ZERO && w.a == 4'd0)) m_reg[w.a] = w.d;
      end
      if (fwe) m_psr = fin;
    end
    #1;
    if (m_known) begin
      for (int i = 0; i < 16; i++)
        check($sformatf("r%0d", i), {16'b0, r_out[i]}, {16'b0, m_reg[i]});
      check("psr", {27'b0, psr}, {27'b0, m_psr});
      check("pend_valid", {31'b0, pend_valid}, {31'b0, m_q.size() != 0});
    end
  endtask

  task automatic idle(input bit st);
    cycle(1'b0, 1'b0, 4'd0, 16'h0, st, 1'b0, 5'd0);
  endtask

  initial begin
    // 1: reset, plain write
    cycle(1'b1, 1'b1, 4'd9, 16'hAAAA, 1'b1, 1'b1, 5'h1F);
    check("reset_pend", {31'b0, pend_valid}, 32'd0);
    check("reset_psr", {27'b0, psr}, 32'd0);
    cycle(1'b0, 1'b1, 4'd5, 16'h1234, 1'b0, 1'b0, 5'd0);
    check("t1_r5", {16'b0, r_out[5]}, 32'h1234);
    check("t1_pend", {31'b0, pend_valid}, 32'd0);

    // 2: stalled write goes to the buffer, commits on release
    cycle(1'b0, 1'b1, 4'd3, 16'hBEEF, 1'b1, 1'b0, 5'd0);
    check("t2_pend", {31'b0, pend_valid}, 32'd1);
    check("t2_ready_low", {31'b0, wr_ready}, 32'd0);
    check("t2_r3_held", {16'b0, r_out[3]}, 32'h0);
    idle(1'b0);
    check("t2_r3", {16'b0, r_out[3]}, 32'hBEEF);
    check("t2_pend_clr", {31'b0, pend_valid}, 32'd0);

    // 3: same-address ordering
    cycle(1'b0, 1'b1, 4'd7, 16'h0001, 1'b1, 1'b0, 5'd0);
    idle(1'b1);
    cycle(1'b0, 1'b1, 4'd7, 16'h0002, 1'b0, 1'b0, 5'd0);
    check("t3_r7_e1", {16'b0, r_out[7]}, 32'h0001);
    check("t3_pend_e1", {31'b0, pend_valid}, 32'd1);
    idle(1'b0);
    check("t3_r7_e2", {16'b0, r_out[7]}, 32'h0002);
    check("t3_pend_e2", {31'b0, pend_valid}, 32'd0);

    // 4: flags while a write is pending
    cycle(1'b0, 1'b1, 4'd10, 16'hC0DE, 1'b1, 1'b0, 5'd0);
    cycle(1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 1'b1, 5'b10101);
    check("t4_psr", {27'b0, psr}, 32'b10101);
    idle(1'b0);
    check("t4_r10", {16'b0, r_out[10]}, 32'hC0DE);

    // 5: reset discards a pending write
    cycle(1'b0, 1'b1, 4'd12, 16'h5A5A, 1'b1, 1'b0, 5'd0);
    cycle(1'b1, 1'b0, 4'd0, 16'h0, 1'b1, 1'b0, 5'd0);
    idle(1'b0);
    check("t5_r12", {16'b0, r_out[12]}, 32'h0);
    check("t5_r5", {16'b0, r_out[5]}, 32'h0);
    check("t5_pend", {31'b0, pend_valid}, 32'd0);

    // 6: address 0
    cycle(1'b0, 1'b1, 4'd0, 16'hFFFF, 1'b0, 1'b0, 5'd0);
    check("t6_r0", {16'b0, r_out[0]}, R0_ZERO ? 32'h0 : 32'hFFFF);

    // randomized traffic against the queue model
    for (int n = 0; n < 3000; n++) begin
      cycle(($urandom_range(0, 99) == 0), $urandom_range(0, 1),
            4'($urandom_range(0, 15)), 16'($urandom),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
            5'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
